clk2ph_gen: RTL



---
 rtl/clk2ph_pkg.sv | 16 +
 rtl/clk2ph_cnt.sv | 33 +++
 rtl/clk2ph_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/clk2ph_pkg.sv
// Shared types and constants for the two-phase latch-enable generator.
// Holds the FSM state encoding and the default counter width.
package clk2ph_pkg;

   localparam int STATE_W   = 3;
   localparam int DEF_CNT_W = 8;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 3'd0,
      P1   = 3'd1,
      GAP1 = 3'd2,
      P2   = 3'd3,
      GAP2 = 3'd4
   } state_t;

endpackage

// File: rtl/clk2ph_cnt.sv
// Loadable down-counter shared by all high and dead-time intervals.
// It saturates at zero, so a length of 2^CNT_W-1 never wraps.
module clk2ph_cnt
   import clk2ph_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             i_ck,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_loadVal,
   output logic [CNT_W-1:0] o_count,
   output logic             o_zero
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_ck or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadVal;
      end else if (r_count != '0) begin
         r_count <= r_count - ONE;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/clk2ph_gen.sv
// Two-phase non-overlapping latch-enable generator (Phi1 -> master, Phi2 -> slave).
// Optional overlap checker driving o_err is built when CLK2PH_OVERLAP_CHK_EN is defined.
module clk2ph_gen
   import clk2ph_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int DEF_HIGH = 4,
   parameter int DEF_GAP  = 1
) (
   input  logic             i_ck,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_highLen,
   input  logic [CNT_W-1:0] i_gapLen,
   output logic             o_phi1,
   output logic             o_phi2,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);

   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
   localparam logic [CNT_W-1:0] DEF_G = CNT_W'(DEF_GAP);

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_highLen;
   logic [CNT_W-1:0] r_gapLen;
   logic [CNT_W-1:0] w_highSel;
   logic [CNT_W-1:0] w_gapSel;
   logic [CNT_W-1:0] w_nextHigh;
   logic [CNT_W-1:0] w_nextGap;
   logic [CNT_W-1:0] w_loadVal;
   logic [CNT_W-1:0] w_count;
   logic [CNT_W-1:0] w_nextCount;
   logic             w_load;
   logic             w_zero;
   logic             r_phi1;
   logic             r_phi2;
   logic             r_busy;
   logic             r_done;

   // A zero length would collapse a phase, so it falls back to the default.
   assign w_highSel = (i_highLen == '0) ? DEF_H : i_highLen;
   assign w_gapSel  = (i_gapLen == '0)  ? DEF_G : i_gapLen;

   clk2ph_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .i_ck      (i_ck),
      .i_rst     (i_rst),
      .i_load    (w_load),
      .i_loadVal (w_loadVal),
      .o_count   (w_count),
      .o_zero    (w_zero)
   );

   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_loadVal   = '0;
      w_nextHigh  = r_highLen;
      w_nextGap   = r_gapLen;
      case (r_state)
         IDLE: begin
            if (i_en) begin
               w_nextState = P1;
               w_load      = 1'b1;
               w_nextHigh  = w_highSel;
               w_nextGap   = w_gapSel;
               w_loadVal   = w_highSel - ONE;
            end
         end
         P1: begin
            if (w_zero) begin
               w_nextState = GAP1;
               w_load      = 1'b1;
               w_loadVal   = r_gapLen - ONE;
            end
         end
         GAP1: begin
            if (w_zero) begin
               w_nextState = P2;
               w_load      = 1'b1;
               w_loadVal   = r_highLen - ONE;
            end
         end
         P2: begin
            if (w_zero) begin
               w_nextState = GAP2;
               w_load      = 1'b1;
               w_loadVal   = r_gapLen - ONE;
            end
         end
         GAP2: begin
            if (w_zero) begin
               if (i_en) begin
                  w_nextState = P1;
                  w_load      = 1'b1;
                  w_nextHigh  = w_highSel;
                  w_nextGap   = w_gapSel;
                  w_loadVal   = w_highSel - ONE;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Mirrors the counter's own update so Done can be registered in step with it.
   assign w_nextCount = w_load ? w_loadVal : (w_zero ? '0 : (w_count - ONE));

   always_ff @(posedge i_ck or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_highLen <= DEF_H;
         r_gapLen  <= DEF_G;
         r_phi1    <= 1'b0;
         r_phi2    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_highLen <= w_nextHigh;
         r_gapLen  <= w_nextGap;
         r_phi1    <= (w_nextState == P1);
         r_phi2    <= (w_nextState == P2);
         r_busy    <= (w_nextState != IDLE);
         r_done    <= (w_nextState == GAP2) && (w_nextCount == '0);
      end
   end

   assign o_phi1 = r_phi1;
   assign o_phi2 = r_phi2;
   assign o_busy = r_busy;
   assign o_done = r_done;

`ifdef CLK2PH_OVERLAP_CHK_EN
   logic r_phi1Q;
   logic r_phi2Q;
   logic r_err;
   logic w_phi1Fall;
   logic w_phi2Rise;

   // Zero dead time shows up as Phi1 falling on the very edge Phi2 rises.
   assign w_phi1Fall = r_phi1Q & ~r_phi1;
   assign w_phi2Rise = ~r_phi2Q & r_phi2;

   always_ff @(posedge i_ck or posedge i_rst) begin
      if (i_rst) begin
         r_phi1Q <= 1'b0;
         r_phi2Q <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_phi1Q <= r_phi1;
         r_phi2Q <= r_phi2;
         r_err   <= r_err | (r_phi1 & r_phi2) | (w_phi1Fall & w_phi2Rise);
      end
   end

   assign o_err = r_err;
`else
   assign o_err = 1'b0;
`endif

endmodule
